// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: datapath <-> data-memory request/response bundle.
//   master (datapath): drives Memread, MemWrite, addr, write_data;
//                      receives read_data, stall, done (and err).
//   slave  (memory)  : the reverse.
// err exists only when DMEM_ALIGN_CHECK_EN is defined.
interface data_memory_responder_if;
  logic        Memread;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic        done;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        err;

  modport master (output Memread, MemWrite, addr, write_data,
                  input  read_data, stall, done, err);
  modport slave  (input  Memread, MemWrite, addr, write_data,
                  output read_data, stall, done, err);
`else
  modport master (output Memread, MemWrite, addr, write_data,
                  input  read_data, stall, done);
  modport slave  (input  Memread, MemWrite, addr, write_data,
                  output read_data, stall, done);
`endif
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: multi-cycle word-addressed data memory for lw/sw.
// A request seen in IDLE is latched, held for WAIT_STATES cycles while stall
// is raised, committed on the edge entering RESP, and reported by a one-cycle
// done pulse in RESP.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (memory contents are not cleared)
//   bus   : data_memory_responder_if.slave (Memread, MemWrite, addr,
//           write_data in; read_data, stall, done [, err] out)
// Optional feature macro: DMEM_ALIGN_CHECK_EN adds the err output, which flags
// misaligned addresses and simultaneous read+write requests.
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input logic                    clk,
  input logic                    reset,
  data_memory_responder_if.slave bus
);

  localparam int  DEPTH     = 2 ** ADDR_WIDTH;
  localparam bit  ZERO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic                    rd_q, wr_q;
  logic [31:0]             rdata_q;
  logic                    done_q;
  logic [31:0]             mem [DEPTH];

  logic                    req, accept, commit;
  logic [ADDR_WIDTH-1:0]   c_idx;
  logic [31:0]             c_wdata;
  logic                    c_rd, c_wr, c_bad;

  logic                    unused_addr;
  assign unused_addr = ^{bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};

  assign req    = bus.Memread | bus.MemWrite;
  assign accept = (state == IDLE) && req;

  // With zero wait states the commit happens on the accept edge, so the
  // access must come straight from the bus instead of the latched copies.
  assign c_idx   = accept ? bus.addr[ADDR_WIDTH+1:2] : idx_q;
  assign c_wdata = accept ? bus.write_data           : wdata_q;
  assign c_rd    = accept ? bus.Memread              : rd_q;
  assign c_wr    = accept ? bus.MemWrite             : wr_q;
  assign commit  = (accept && ZERO_WAIT) || ((state == WAIT) && (cnt == 4'd1));

`ifdef DMEM_ALIGN_CHECK_EN
  logic bad_q, in_bad, err_q;
  assign in_bad  = (bus.addr[1:0] != 2'b00) || (bus.Memread && bus.MemWrite);
  assign c_bad   = accept ? in_bad : bad_q;
  assign bus.err = err_q;
`else
  assign c_bad   = 1'b0;
`endif

  // Reset gating keeps stall low even while a request is held during reset.
  assign bus.stall     = reset && (accept || (state == WAIT));
  assign bus.done      = done_q;
  assign bus.read_data = rdata_q;

  // Array has no reset; a write is committed only outside reset.
  always_ff @(posedge clk) begin
    if (reset && commit && c_wr && !c_bad)
      mem[c_idx] <= c_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      err_q  <= 1'b0;
`endif
      if (commit) begin
        done_q <= 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
        err_q  <= c_bad;
`endif
        // Write wins over read when both are set; read_data then holds.
        if (c_bad)
          rdata_q <= 32'd0;
        else if (c_rd && !c_wr)
          rdata_q <= mem[c_idx];
      end

      case (state)
        IDLE: if (req) begin
          idx_q   <= bus.addr[ADDR_WIDTH+1:2];
          wdata_q <= bus.write_data;
          rd_q    <= bus.Memread;
          wr_q    <= bus.MemWrite;
`ifdef DMEM_ALIGN_CHECK_EN
          bad_q   <= in_bad;
`endif
          cnt     <= 4'(WAIT_STATES);
          state   <= ZERO_WAIT ? RESP : WAIT;
        end
        WAIT: begin
          if (cnt == 4'd1) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        // Requests seen here belong to the retiring instruction.
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: dut_a uses WAIT_STATES=2, dut_b uses
// WAIT_STATES=0. Expected results are pushed to a scoreboard queue at drive
// time and popped when done pulses.
module tb_data_memory_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_memory_responder_if ifa ();
  data_memory_responder_if ifb ();

  data_memory_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  data_memory_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] model_mem [logic [7:0]];
  logic [31:0] last_rd [2];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_bad(input logic rd, input logic wr, input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return (a[1:0] != 2'b00) || (rd && wr);
`else
    return 1'b0 & rd & wr & a[0];
`endif
  endfunction

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      ifa.Memread = rd; ifa.MemWrite = wr; ifa.addr = a; ifa.write_data = d;
    end else begin
      ifb.Memread = rd; ifb.MemWrite = wr; ifb.addr = a; ifb.write_data = d;
    end
  endtask

  // Called just after a rising edge with the DUT in IDLE. Checks stall
  // length, done latency and the scoreboard entry.
  task automatic access(input int sel, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
    int   ws      = (sel == 0) ? 2 : 0;
    int   stall_n = 0;
    bit   got     = 0;
    logic s, dn, e_o;
    logic [31:0] rdo;
    exp_t e;
    if (is_bad(rd, wr, a))  last_rd[sel] = 32'd0;
    else if (wr)            model_mem[a[9:2]] = d;
    else if (rd)            last_rd[sel] = model_mem[a[9:2]];
    e.rdata = last_rd[sel];
    e.err   = is_bad(rd, wr, a);
    sbq.push_back(e);
    drive(sel, rd, wr, a, d);
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      s   = (sel == 0) ? ifa.stall     : ifb.stall;
      dn  = (sel == 0) ? ifa.done      : ifb.done;
      rdo = (sel == 0) ? ifa.read_data : ifb.read_data;
`ifdef DMEM_ALIGN_CHECK_EN
      e_o = (sel == 0) ? ifa.err : ifb.err;
`else
      e_o = 1'b0;
`endif
      if (dn) begin
        got = 1;
        e   = sbq.pop_front();
        check("done_latency", c, ws + 1);
        check("stall_cycles", stall_n, ws + 1);
        check("stall_in_resp", {31'd0, s}, 32'd0);
        check("read_data", rdo, e.rdata);
`ifdef DMEM_ALIGN_CHECK_EN
        check("err", {31'd0, e_o}, {31'd0, e.err});
`endif
        drive(sel, 1'b0, 1'b0, a, d);
      end else if (s) begin
        stall_n++;
      end
    end
    checks++;
    assert (got) else begin
      failures++;
      $error("FAIL done_timeout observed=no_done expected=done");
      void'(sbq.pop_front());
      drive(sel, 1'b0, 1'b0, a, d);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
    drive(1, 1'b1, 1'b0, 32'h10, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;

    // Held request during reset must not stall or complete.
    repeat (2) @(negedge clk);
    check("rst_stall_a", {31'd0, ifa.stall}, 32'd0);
    check("rst_done_a",  {31'd0, ifa.done},  32'd0);
    check("rst_rdata_a", ifa.read_data,      32'd0);
    check("rst_stall_b", {31'd0, ifb.stall}, 32'd0);
    check("rst_done_b",  {31'd0, ifb.done},  32'd0);
    check("rst_rdata_b", ifb.read_data,      32'd0);

    // Release with a write held: accepted in the very next cycle.
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(0, 1'b0, 1'b1, 32'h20, 32'h11112222);
    reset = 1'b1;
    access(0, 1'b0, 1'b1, 32'h20, 32'h11112222);

    // Store then load, aliasing and top-of-memory.
    access(0, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 32'h10,  32'd0);
    access(0, 1'b1, 1'b0, 32'h410, 32'd0);
    access(0, 1'b0, 1'b1, 32'h30,  32'hA5A5A5A5);
    access(0, 1'b1, 1'b1, 32'h30,  32'h0BADF00D);
    access(0, 1'b1, 1'b0, 32'h30,  32'd0);
    access(0, 1'b1, 1'b0, 32'h13,  32'd0);
    access(0, 1'b0, 1'b1, 32'h3FC, 32'hFFFFFFFF);
    access(0, 1'b1, 1'b0, 32'h3FC, 32'd0);

    // Continuously held read: one done every 4 cycles, no double accept.
    drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
    last_rd[0] = model_mem[8'h04];
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("held_done",  {31'd0, ifa.done},  {31'd0, (c % 4) == 3});
      check("held_stall", {31'd0, ifa.stall}, {31'd0, (c % 4) != 3});
      if (ifa.done) check("held_rdata", ifa.read_data, last_rd[0]);
    end
    drive(0, 1'b0, 1'b0, 32'h10, 32'd0);
    @(posedge clk); #1;

    // Reset mid-WAIT discards the pending write.
    drive(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    check("midrst_stall", {31'd0, ifa.stall}, 32'd0);
    check("midrst_done",  {31'd0, ifa.done},  32'd0);
    check("midrst_rdata", ifa.read_data,      32'd0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h20, 32'd0);
    reset = 1'b1;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, 32'h20, 32'd0);

`ifdef DMEM_ALIGN_CHECK_EN
    access(0, 1'b0, 1'b1, 32'h22, 32'h55555555);
    access(0, 1'b1, 1'b0, 32'h20, 32'd0);
    access(0, 1'b1, 1'b1, 32'h10, 32'h77777777);
`endif

    // Zero wait states: stall for the accept cycle only, done next cycle.
    access(1, 1'b0, 1'b1, 32'h40, 32'h600DCAFE);
    access(1, 1'b1, 1'b0, 32'h40, 32'd0);
    access(1, 1'b0, 1'b1, 32'h44, 32'h0000FFFF);
    access(1, 1'b1, 1'b0, 32'h44, 32'd0);
    access(1, 1'b1, 1'b0, 32'h40, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Multi-cycle data-memory slave that services the `Memread`/`MemWrite` requests the control unit issues for `lw`/`sw`. It holds a word-addressed RAM, inserts a fixed number of wait states, and drives `stall` back to the datapath until the access completes. It sits between the ALU result and `write_data` register-file paths on one side and the `MemtoReg` mux on the other. It replaces a zero-latency combinational memory.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: word-index width; depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, 2: extra cycles per access; legal range is 0–15.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `Memread`  in  1  read request; level, held by the datapath while `stall`=1.
- `MemWrite`  in  1  write request; level, held while `stall`=1.
- `addr`  in  32  byte address; the word index is `addr[ADDR_WIDTH+1:2]`.
- `write_data`  in  32  store data.
- `read_data`  out  32  registered load data; valid while `done`=1 and held until the next read completes.
- `stall`  out  1  freezes PC and pipeline registers; combinational.
- `done`  out  1  one-cycle pulse marking the completion cycle.
- `err`  out  1  access error, qualified by `done` (exists only with `DMEM_ALIGN_CHECK_EN`).

Clocking and reset: one clock; reset is asynchronous and active-low.

## Operation
- The state machine has three states: IDLE, WAIT and RESP. The 4-bit `cnt` register is the wait counter.
- `req` = `Memread | MemWrite`.
- IDLE:
  - When `req`=1, latch `addr` index, `write_data`, the read flag and the write flag.
  - Load `cnt` = `WAIT_STATES`.
  - Go to WAIT, or go directly to RESP if `WAIT_STATES`=0.
  - `stall` = `req`.
- WAIT:
  - `stall`=1.
  - If `cnt`==1, go to RESP; otherwise decrement `cnt`.
  - On the edge that enters RESP, commit the access from the latched values:
    - Write: `mem[idx]` ← data.
    - Read: `read_data` ← `mem[idx]`.
- RESP:
  - `done`=1, `stall`=0.
  - Any `req` present in this cycle is ignored, because it belongs to the instruction now retiring.
  - Unconditionally return to IDLE.
- When `Memread` and `MemWrite` are both 1, the write wins and `read_data` is unchanged.
- Inputs are ignored outside IDLE; the latched copies are authoritative.
- Memory contents are not cleared by reset. They are undefined until written.

## Timing
- Reset (`reset`=0):
  - State is IDLE, `cnt`=0, `read_data`=0, `done`=0, `err`=0.
  - `stall` is forced to 0.
  - A pending access is discarded; no write is committed.
- Latency: a request seen in IDLE cycle N produces `done` in cycle N+`WAIT_STATES`+1.
  - `stall` is high for cycles N through N+`WAIT_STATES`.
  - With `WAIT_STATES`=2: `stall` is high for 3 cycles, and `done` asserts in the 4th cycle.
- Back-to-back requests: the minimum spacing between accepts is `WAIT_STATES`+2 cycles, because RESP always passes through IDLE.
- When `req`=0 in IDLE, `stall`=0, `done`=0, and `read_data` holds its value.
- Reset asserted mid-WAIT takes effect asynchronously. The memory array is left untouched.

## Configuration
`DMEM_ALIGN_CHECK_EN` compiles the alignment and conflict check in or out.

With the macro defined:
- An access is flagged when `addr[1:0]`≠0, or when both requests are set.
- A flagged access still runs the full FSM and latency.
- In the commit edge, a flagged access writes nothing and loads `read_data`=0.
- `err`=1 during the RESP cycle only.

Without the macro:
- The `err` port and its logic are absent.
- `addr[1:0]` is ignored.
- Both requests set resolves as a write only.

## Test plan
- Reset check: hold `reset`=0 with `Memread`=1 → `stall`=0, `done`=0, `read_data`=0. Release reset → the request is accepted in the next cycle.
- Store then load, `WAIT_STATES`=2: `MemWrite` with `addr`=0x10 and data 0xDEADBEEF → `stall` is high for 3 cycles and `done` asserts in cycle 4. Then `Memread` `addr`=0x10 → `read_data`=0xDEADBEEF with `done` after the same latency.
- `WAIT_STATES`=0: a read is accepted in cycle N → `done` and valid `read_data` in cycle N+1, and `stall` is high for cycle N only.
- Held request through RESP: keep `Memread` asserted continuously → exactly one `done` per `WAIT_STATES`+2 cycles, with no double accept.
- Reset mid-WAIT: a write of 0x12345678 to 0x20 interrupted by `reset` → a later read of 0x20 returns the prior value, not 0x12345678.
- With `DMEM_ALIGN_CHECK_EN`: write to `addr`=0x22 → `err`=1 with `done`, and the memory is unchanged. `Memread` and `MemWrite` both set → `err`=1 and `read_data`=0.
